video_driver: RTL and testbench
===============================

VIDEO_DRIVER -- requirements
Module: video_driver

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_SYNC 11'd40 hsync width; H_BACK 11'd220 h back porch; H_DISP 11'd1280 active width; H_FRONT 11'd110 h front porch; H_TOTAL 11'd1650 line period.
  V_SYNC 11'd5 vsync lines; V_BACK 11'd20 v back porch; V_DISP 11'd720 active lines; V_FRONT 11'd5 v front porch; V_TOTAL 11'd750 frame period.
REQ-002 Ports (name, direction, width, meaning):
  pixel_clk  in  1  sole clock, rising edge.
  sys_rst  in  1  asynchronous, active-high reset.
  run  in  1  timing enable level.
  pixel_data  in  24  RGB888 from pixel generator, registered there (1-cycle latency from xpos/ypos).
  pixel_xpos  out  11  requested pixel column.
  pixel_ypos  out  11  requested pixel row.
  video_hs  out  1  hsync, active high.
  video_vs  out  1  vsync, active high.
  video_de  out  1  active-video data enable.
  video_rgb  out  24  RGB888 to encoder.
  frame_start  out  1  one-cycle pulse at first clock of each frame.
  busy  out  1  high while not IDLE.

Function
REQ-003 Counters: cnt_h 0..H_TOTAL-1 increments every RUN/STOPPING cycle, wraps to 0 after H_TOTAL-1; cnt_v 0..V_TOTAL-1 increments only when cnt_h wraps, wraps to 0 after V_TOTAL-1 coincident with cnt_h wrap.
REQ-004 FSM states IDLE, RUN, STOPPING; IDLE->RUN when run=1 (counters already 0; first RUN cycle is cnt_h=0, cnt_v=0).
REQ-005 RUN->STOPPING when run=0; STOPPING->RUN when run=1 again (no counter disturbance).
REQ-006 STOPPING->IDLE on the cycle cnt_h=H_TOTAL-1 and cnt_v=V_TOTAL-1; counters load 0; current frame always completes.
REQ-007 In IDLE counters hold 0; all outputs 0; busy=0. busy=1 in RUN and STOPPING.
REQ-008 video_hs = (cnt_h < H_SYNC) outside IDLE; video_vs = (cnt_v < V_SYNC) outside IDLE; decoded from registered counters, no added latency.
REQ-009 video_de = 1 iff cnt_h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP-1] and cnt_v in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP-1], outside IDLE.
REQ-010 data_req (internal) = same as video_de but with the h window shifted one cycle earlier: [H_SYNC+H_BACK-1, H_SYNC+H_BACK+H_DISP-2].
REQ-011 pixel_xpos = cnt_h-(H_SYNC+H_BACK-1) and pixel_ypos = cnt_v-(V_SYNC+V_BACK) while data_req=1; both 0 otherwise; range 0..H_DISP-1 / 0..V_DISP-1, never exceeds.
REQ-012 video_rgb = pixel_data while video_de=1, else 24'd0; so the pixel requested at xpos=N appears on video_rgb in the cycle de covers column N.
REQ-013 frame_start = 1 exactly when busy-state is RUN/STOPPING and cnt_h=0, cnt_v=0; includes the first cycle after leaving IDLE.
REQ-014 Active-line count per frame = V_DISP; de-high cycles per active line = H_DISP; hs-high cycles per line = H_SYNC; vs-high lines per frame = V_SYNC.
REQ-015 Arithmetic 11-bit unsigned; parameters must satisfy H_SYNC+H_BACK+H_DISP+H_FRONT=H_TOTAL ≤ 2047 (same for V); violation is a configuration error, behaviour undefined.

Reset
REQ-016 sys_rst=1 asynchronously forces IDLE, cnt_h=cnt_v=0, all outputs 0, regardless of run or mid-frame position.
REQ-017 After sys_rst deasserts with run=1, the first rising edge enters RUN; frame_start asserts on the following cycle.

Verification
REQ-018 Default params, run=1 from reset -> frame_start every 1237500 cycles; hs high 40 cycles per 1650; vs high 5 lines (8250 cycles); de high 1280 cycles/line on 720 lines.
REQ-019 Pixel generator model returning {xpos,ypos} registered -> on every de cycle video_rgb equals column/row of that de pixel; first de cycle of frame shows x=0,y=0 at cnt_h=260,cnt_v=25; last shows 1279,719.
REQ-020 run=0 at cnt_v=100 -> frame finishes, busy falls after cnt_v=749/cnt_h=1649 cycle; no frame_start; all outputs 0 afterwards.
REQ-021 run toggles 0 then 1 within a frame -> no glitch, counters continuous, next frame_start at normal period.
REQ-022 sys_rst pulsed mid-active-line (cnt_h=700,cnt_v=300) -> outputs 0 immediately (async), restart at cnt 0,0 with frame_start one cycle after release.
REQ-023 Small params (H 2/2/4/2/10, V 1/1/3/1/6) -> exact waveform compare of hs/vs/de/xpos/ypos against cycle table for two frames.

Source files
------------

// File: rtl/video_driver.sv
// Display timing generator: hsync/vsync/de from free-running h/v counters, with a
// one-cycle-early pixel request so a registered pixel source lines up with de.
module video_driver #(
  parameter logic [10:0] H_SYNC  = 11'd40,
  parameter logic [10:0] H_BACK  = 11'd220,
  parameter logic [10:0] H_DISP  = 11'd1280,
  parameter logic [10:0] H_FRONT = 11'd110,
  parameter logic [10:0] H_TOTAL = 11'd1650,
  parameter logic [10:0] V_SYNC  = 11'd5,
  parameter logic [10:0] V_BACK  = 11'd20,
  parameter logic [10:0] V_DISP  = 11'd720,
  parameter logic [10:0] V_FRONT = 11'd5,
  parameter logic [10:0] V_TOTAL = 11'd750
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic        run,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [23:0] video_rgb,
  output logic        frame_start,
  output logic        busy
);

  localparam logic [10:0] H_ACT0 = H_SYNC + H_BACK;
  localparam logic [10:0] H_ACT1 = H_ACT0 + H_DISP - 11'd1;
  localparam logic [10:0] V_ACT0 = V_SYNC + V_BACK;
  localparam logic [10:0] V_ACT1 = V_ACT0 + V_DISP - 11'd1;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t      state, state_nxt;
  logic [10:0] cnt_h, cnt_v, cnt_h_nxt, cnt_v_nxt;
  logic        h_last, v_last, active, h_de, h_req, v_act, data_req;

  assign h_last = (cnt_h == H_TOTAL - 11'd1);
  assign v_last = (cnt_v == V_TOTAL - 11'd1);

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      cnt_h <= '0;
      cnt_v <= '0;
    end else begin
      state <= state_nxt;
      cnt_h <= cnt_h_nxt;
      cnt_v <= cnt_v_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_h_nxt = cnt_h;
    cnt_v_nxt = cnt_v;
    case (state)
      IDLE: begin
        cnt_h_nxt = '0;
        cnt_v_nxt = '0;
        if (run) state_nxt = RUN;
      end
      RUN, STOPPING: begin
        cnt_h_nxt = h_last ? 11'd0 : cnt_h + 11'd1;
        if (h_last) cnt_v_nxt = v_last ? 11'd0 : cnt_v + 11'd1;
        // Dropping run never truncates a frame; IDLE is only entered on its last cycle.
        if (run)                 state_nxt = RUN;
        else if (h_last && v_last) state_nxt = IDLE;
        else                     state_nxt = STOPPING;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign active   = (state != IDLE);
  assign h_de     = (cnt_h >= H_ACT0) && (cnt_h <= H_ACT1);
  assign h_req    = (cnt_h >= H_ACT0 - 11'd1) && (cnt_h <= H_ACT1 - 11'd1);
  assign v_act    = (cnt_v >= V_ACT0) && (cnt_v <= V_ACT1);
  assign data_req = active && h_req && v_act;

  assign busy        = active;
  assign video_hs    = active && (cnt_h < H_SYNC);
  assign video_vs    = active && (cnt_v < V_SYNC);
  assign video_de    = active && h_de && v_act;
  assign frame_start = active && (cnt_h == 11'd0) && (cnt_v == 11'd0);
  assign pixel_xpos  = data_req ? cnt_h - (H_ACT0 - 11'd1) : 11'd0;
  assign pixel_ypos  = data_req ? cnt_v - V_ACT0 : 11'd0;
  assign video_rgb   = video_de ? pixel_data : 24'd0;

endmodule

// File: tb/tb_video_driver.sv
// Bench for video_driver on a 10x6 frame; a frame-position model feeds a scoreboard
// queue checked every cycle, with a registered {x,y} pixel generator on pixel_data.
module tb_video_driver;

  logic        pixel_clk = 1'b0;
  logic        sys_rst, run;
  logic [23:0] pixel_data = 24'd0;
  logic [10:0] pixel_xpos, pixel_ypos;
  logic        video_hs, video_vs, video_de, frame_start, busy;
  logic [23:0] video_rgb;

  video_driver #(
    .H_SYNC(11'd2), .H_BACK(11'd2), .H_DISP(11'd4), .H_FRONT(11'd2), .H_TOTAL(11'd10),
    .V_SYNC(11'd1), .V_BACK(11'd1), .V_DISP(11'd3), .V_FRONT(11'd1), .V_TOTAL(11'd6)
  ) dut (
    .pixel_clk(pixel_clk), .sys_rst(sys_rst), .run(run), .pixel_data(pixel_data),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .video_hs(video_hs),
    .video_vs(video_vs), .video_de(video_de), .video_rgb(video_rgb),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 pixel_clk = ~pixel_clk;

  // pixel source with one cycle of latency, encoding the requested coordinates
  always @(posedge pixel_clk) pixel_data <= {pixel_xpos, pixel_ypos, 2'b00};

  typedef struct packed {
    logic        hs, vs, de;
    logic [10:0] x, y;
    logic [23:0] rgb;
    logic        fs, bsy;
  } obs_t;

  obs_t q[$];
  int   n_tests = 0, n_fail = 0, cyc = 0;
  bit   m_busy = 1'b0;
  int   m_t = 0;
  int   c_de, c_hs, c_vs, c_fs;

  function automatic obs_t expect_of(bit b, int t);
    obs_t e;
    int h, v;
    e = '0;
    h = t % 10;
    v = t / 10;
    if (b) begin
      e.bsy = 1'b1;
      e.hs  = (h < 2);
      e.vs  = (v < 1);
      e.fs  = (t == 0);
      e.de  = (h >= 4 && h <= 7 && v >= 2 && v <= 4);
      if (h >= 3 && h <= 6 && v >= 2 && v <= 4) begin
        e.x = 11'(h - 3);
        e.y = 11'(v - 2);
      end
      if (e.de) e.rgb = {11'(h - 4), 11'(v - 2), 2'b00};
    end
    return e;
  endfunction

  function automatic obs_t observe();
    return '{video_hs, video_vs, video_de, pixel_xpos, pixel_ypos, video_rgb, frame_start, busy};
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc%0d got hs%b vs%b de%b x%0d y%0d rgb%h fs%b busy%b, expected hs%b vs%b de%b x%0d y%0d rgb%h fs%b busy%b",
             tag, cyc, got.hs, got.vs, got.de, got.x, got.y, got.rgb, got.fs, got.bsy,
             exp.hs, exp.vs, exp.de, exp.x, exp.y, exp.rgb, exp.fs, exp.bsy);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_tests++;
    assert (got == exp) else begin
      n_fail++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input string tag);
    obs_t got;
    @(posedge pixel_clk);
    cyc++;
    if (sys_rst) begin
      m_busy = 1'b0;
      m_t = 0;
    end else if (!m_busy) begin
      if (run) begin
        m_busy = 1'b1;
        m_t = 0;
      end
    end else if (m_t == 59) begin
      m_t = 0;
      if (!run) m_busy = 1'b0;
    end else begin
      m_t++;
    end
    q.push_back(expect_of(m_busy, m_t));
    #1;
    got = observe();
    c_de += got.de;
    c_hs += got.hs;
    c_vs += got.vs;
    c_fs += got.fs;
    check(tag, got, q.pop_front());
  endtask

  task automatic run_until(input int t, input string tag);
    int n;
    n = 0;
    while (!(m_busy && m_t == t) && n < 200) begin
      tick(tag);
      n++;
    end
    check_int({tag, "_reach"}, int'(m_busy && m_t == t), 1);
  endtask

  initial begin
    sys_rst = 1'b1;
    run = 1'b0;
    #1;
    check("reset_async", observe(), obs_t'(0));
    repeat (3) tick("reset");

    // start from reset with run held high; two full frames counted
    @(negedge pixel_clk);
    sys_rst = 1'b0;
    run = 1'b1;
    c_de = 0; c_hs = 0; c_vs = 0; c_fs = 0;
    repeat (120) tick("run");
    check_int("de_cycles_2frames", c_de, 24);
    check_int("hs_cycles_2frames", c_hs, 24);
    check_int("vs_cycles_2frames", c_vs, 20);
    check_int("frame_starts", c_fs, 2);

    // drop run mid-frame: frame completes, then IDLE with no further frame_start
    run_until(25, "pre_stop");
    @(negedge pixel_clk);
    run = 1'b0;
    c_fs = 0;
    repeat (45) tick("stopping");
    check_int("no_fs_after_stop", c_fs, 0);
    check_int("idle_after_stop", int'(busy), 0);

    // restart, then a brief run=0 glitch inside the frame
    @(negedge pixel_clk);
    run = 1'b1;
    repeat (20) tick("restart");
    @(negedge pixel_clk);
    run = 1'b0;
    repeat (3) tick("glitch_low");
    @(negedge pixel_clk);
    run = 1'b1;
    c_fs = 0;
    repeat (70) tick("glitch_high");
    check_int("fs_after_glitch", c_fs, 1);

    // async reset in the middle of an active line
    run_until(35, "pre_rst");
    @(negedge pixel_clk);
    #2;
    sys_rst = 1'b1;
    #1;
    check("rst_midline", observe(), obs_t'(0));
    repeat (2) tick("rst_hold");
    @(negedge pixel_clk);
    sys_rst = 1'b0;
    tick("rst_release_enter");
    check_int("fs_after_release", int'(frame_start), 1);
    repeat (10) tick("after_rst");

    // drop run exactly on the second-to-last cycle: last cycle runs, then IDLE
    run_until(58, "pre_edge_stop");
    @(negedge pixel_clk);
    run = 1'b0;
    repeat (6) tick("edge_stop");
    check_int("idle_after_edge_stop", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
